// File: rtl/uart_transmitter.sv
// UART transmitter: start, LSB-first data, even parity, stop.
// One-entry holding buffer allows back-to-back frames; break frame support.
module uart_transmitter #(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 tx_start_n,
  input  logic                 break_req,
  output logic                 serial_data_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 overflow_error
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_SIZE + 3);
  localparam logic [CW-1:0] SMP_MAX   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_SIZE - 1);
  localparam logic [BW-1:0] BRK_LAST  = BW'(DATA_SIZE + 1);

  localparam int I_IDLE  = 0;
  localparam int I_START = 1;
  localparam int I_DATA  = 2;
  localparam int I_PAR   = 3;
  localparam int I_STOP  = 4;
  localparam int I_BRK   = 5;

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_START = 6'b000010;
  localparam logic [5:0] S_DATA  = 6'b000100;
  localparam logic [5:0] S_PAR   = 6'b001000;
  localparam logic [5:0] S_STOP  = 6'b010000;
  localparam logic [5:0] S_BRK   = 6'b100000;

  logic [5:0]           state_q, state_d;
  logic [CW-1:0]        smp_q, smp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_SIZE-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 drop_q, drop_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic req;
  logic wrap;
  logic stop_end;

  assign req      = !tx_start_n;
  assign wrap     = (smp_q == SMP_MAX);
  assign stop_end = state_q[I_STOP] && wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      smp_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      drop_q     <= 1'b0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      drop_q     <= drop_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    smp_d      = wrap ? '0 : smp_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    drop_d     = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        smp_d = '0;
        bit_d = '0;
        if (req) begin
          state_d = S_START;
          shift_d = data_in;
          par_d   = ^data_in;
        end else if (break_req && !buf_full_q) begin
          state_d = S_BRK;
        end
      end
      state_q[I_START]: begin
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      state_q[I_DATA]: begin
        if (wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = S_PAR;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      state_q[I_PAR]: begin
        if (wrap) state_d = S_STOP;
      end
      state_q[I_STOP]: begin
        // Chain straight into the next frame so the line never idles.
        if (wrap) begin
          if (buf_full_q) begin
            state_d    = S_START;
            shift_d    = buf_q;
            par_d      = ^buf_q;
            buf_full_d = 1'b0;
          end else if (req) begin
            state_d = S_START;
            shift_d = data_in;
            par_d   = ^data_in;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      state_q[I_BRK]: begin
        if (wrap) begin
          if (bit_q == BRK_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (req && !state_q[I_IDLE]) begin
      if (buf_full_q) begin
        drop_d = 1'b1;
      end else if (!stop_end) begin
        buf_d      = data_in;
        buf_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    line_d = 1'b1;
    unique case (1'b1)
      state_q[I_IDLE]:  line_d = 1'b1;
      state_q[I_START]: line_d = 1'b0;
      state_q[I_DATA]:  line_d = shift_q[0];
      state_q[I_PAR]:   line_d = par_q;
      state_q[I_STOP]:  line_d = 1'b1;
      state_q[I_BRK]:   line_d = 1'b0;
      default:          line_d = 1'b1;
    endcase
    busy_d = !state_q[I_IDLE];
    done_d = stop_end;
    ovf_d  = drop_q;
  end

  assign serial_data_out = line_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;
  assign overflow_error  = ovf_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: vector table, scoreboard-checked
// line decoder, and hand-written multi-frame sequences.
module tb_uart_transmitter;
  logic       clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       tx_start_n;
  logic       break_req;
  logic       serial_data_out;
  logic       tx_busy;
  logic       tx_done;
  logic       overflow_error;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       brk;
    logic       start;
    logic [7:0] exp_data;
    logic       exp_par;
  } vec_t;

  exp_t sb[$];

  uart_transmitter #(
    .DATA_SIZE (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .tx_start_n     (tx_start_n),
    .break_req      (break_req),
    .serial_data_out(serial_data_out),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .overflow_error (overflow_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Line decoder: mid-bit sampling, 11 bits per frame.
  logic mon_bits [11];
  logic mon_in = 1'b0;
  int   mon_off = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_in = 1'b0;
    end else if (!mon_in) begin
      if (serial_data_out == 1'b0) begin
        mon_in  = 1'b1;
        mon_off = 0;
      end
    end else begin
      mon_off++;
    end
    if (mon_in && reset_n) begin
      if (mon_off % 16 == 8) mon_bits[mon_off / 16] = serial_data_out;
      if (mon_off == 168) begin
        logic [7:0] d;
        exp_t e;
        for (int i = 0; i < 8; i++) d[i] = mon_bits[i + 1];
        chk("mon_start_bit", mon_bits[0], 0);
        chk("mon_stop_bit", mon_bits[10], 1);
        chk("mon_frame_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("mon_data", d, e.d);
          chk("mon_parity", mon_bits[9], e.p);
        end
      end
      if (mon_off == 175) mon_in = 1'b0;
    end
  end

  task automatic do_frame(input vec_t v, input string nm);
    int done_c;
    int busy_c;
    logic e160;
    done_c = -1;
    busy_c = -1;
    e160 = v.start ? v.exp_par : 1'b0;
    @(negedge clk);
    tx_start_n = !v.start;
    break_req  = v.brk;
    data_in    = v.data;
    sb.push_back('{v.exp_data, v.exp_par});
    @(negedge clk);
    tx_start_n = 1'b1;
    break_req  = 1'b0;
    data_in    = 8'($urandom);
    chk({nm, "_c0_line"}, serial_data_out, 1);
    chk({nm, "_c0_busy"}, tx_busy, 0);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      if (c == 1) begin
        chk({nm, "_c1_line"}, serial_data_out, 0);
        chk({nm, "_c1_busy"}, tx_busy, 1);
      end
      if (c == 16) chk({nm, "_c16_line"}, serial_data_out, 0);
      if (c == 17) chk({nm, "_c17_line"}, serial_data_out, v.exp_data[0]);
      if (c == 160) chk({nm, "_c160_line"}, serial_data_out, e160);
      if (c == 161) chk({nm, "_c161_line"}, serial_data_out, 1);
      if (tx_done && done_c < 0) done_c = c;
      if (!tx_busy && busy_c < 0) begin
        busy_c = c;
        chk({nm, "_done_pulse_end"}, tx_done, 0);
        break;
      end
    end
    chk({nm, "_done_cycle"}, done_c, 176);
    chk({nm, "_busy_fall"}, busy_c, 177);
  endtask

  task automatic run_seq(input string nm, input logic brk0,
                         input logic [7:0] d0,
                         input int c1, input logic [7:0] d1,
                         input int c2, input logic [7:0] d2,
                         input int e_done1, input int e_done2,
                         input int e_busy, input int e_ovn,
                         input int e_ovc);
    int done1;
    int done2;
    int busyc;
    int ovn;
    int ovc;
    done1 = -1;
    done2 = -1;
    busyc = -1;
    ovn = 0;
    ovc = -1;
    @(negedge clk);
    for (int c = 0; c <= 600; c++) begin
      tx_start_n = !((c == 0 && !brk0) || c == c1 || c == c2);
      break_req  = (c == 0 && brk0);
      if (c == 0) data_in = d0;
      else if (c == c1) data_in = d1;
      else if (c == c2) data_in = d2;
      else data_in = 8'($urandom);
      @(negedge clk);
      if (overflow_error) begin
        ovn++;
        ovc = c;
      end
      if (tx_done) begin
        if (done1 < 0) done1 = c;
        else if (done2 < 0) done2 = c;
      end
      if (c > 0 && !tx_busy) begin
        busyc = c;
        break;
      end
    end
    tx_start_n = 1'b1;
    break_req  = 1'b0;
    chk({nm, "_done1"}, done1, e_done1);
    chk({nm, "_done2"}, done2, e_done2);
    chk({nm, "_busy_fall"}, busyc, e_busy);
    chk({nm, "_ovf_count"}, ovn, e_ovn);
    chk({nm, "_ovf_cycle"}, ovc, e_ovc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [8];
    vec_t vr;
    vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
    vt[1] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1};
    vt[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1};
    vt[5] = '{8'h6B, 1'b0, 1'b1, 8'h6B, 1'b1};
    vt[6] = '{8'hE7, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[7] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};

    reset_n    = 1'b0;
    tx_start_n = 1'b1;
    break_req  = 1'b0;
    data_in    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_line", serial_data_out, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ovf", overflow_error, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_line", serial_data_out, 1);
    chk("idle_busy", tx_busy, 0);

    for (int i = 0; i < 8; i++) begin
      do_frame(vt[i], $sformatf("vec%0d", i));
    end

    sb.push_back('{8'h3C, 1'b0});
    sb.push_back('{8'hC3, 1'b0});
    run_seq("b2b_ovf", 1'b0, 8'h3C, 40, 8'hC3, 60, 8'hFF,
            176, 352, 353, 1, 61);

    sb.push_back('{8'h11, 1'b0});
    sb.push_back('{8'h22, 1'b0});
    run_seq("stop_edge_req", 1'b0, 8'h11, 175, 8'h22, -1, 8'h00,
            176, 352, 353, 0, -1);

    sb.push_back('{8'h00, 1'b0});
    sb.push_back('{8'h33, 1'b0});
    run_seq("brk_buf", 1'b1, 8'h00, 50, 8'h33, 120, 8'h44,
            176, 352, 353, 1, 121);

    @(negedge clk);
    tx_start_n = 1'b0;
    data_in    = 8'h69;
    @(negedge clk);
    tx_start_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_pre_busy", tx_busy, 1);
    chk("midrst_pre_line", serial_data_out, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_line", serial_data_out, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_done", tx_done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    vr = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0};
    do_frame(vr, "post_rst");

    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("final_line", serial_data_out, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DATA_SIZE, default 8, payload bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, clk cycles per serial bit; the value shall match the receiver's sample count.
REQ-003 clk  input  1  sampling clock at OVERSAMPLE x baud; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  DATA_SIZE  byte to send; sampled in the cycle tx_start_n is low.
REQ-006 tx_start_n  input  1  active-low send request, one cycle low per byte.
REQ-007 break_req  input  1  active-high request to send one break frame.
REQ-008 serial_data_out  output  1  registered serial line; idle high.
REQ-009 tx_busy  output  1  high while any frame is being driven.
REQ-010 tx_done  output  1  one-cycle pulse at the end of each frame's stop bit.
REQ-011 overflow_error  output  1  one-cycle pulse when a request is dropped.

Function
REQ-012 The frame shall be: start (0), DATA_SIZE data bits LSB first, parity bit, stop (1).
  - Parity bit = XOR of the data bits (even parity).
  - Each bit lasts exactly OVERSAMPLE cycles.
  - Frame length = (DATA_SIZE+3)*OVERSAMPLE cycles (176 at defaults).
REQ-013 The FSM states shall be IDLE, START, DATA, PARITY, STOP, BREAK, one-hot encoded. Transitions:
  - IDLE->START on an accepted request.
  - START->DATA after OVERSAMPLE cycles.
  - DATA->PARITY after DATA_SIZE bits.
  - PARITY->STOP after OVERSAMPLE cycles.
  - STOP->IDLE, or STOP->START when the holding buffer is full.
REQ-014 Request in IDLE at rising edge N:
  - data_in is latched into the shift register.
  - serial_data_out = 0 and tx_busy = 1 from edge N+1.
  - Latency is one cycle.
REQ-015 A sample counter of width clog2(OVERSAMPLE) shall count 0..OVERSAMPLE-1 per bit and wrap to 0. The bit counter shall advance on the wrap.
REQ-016 The shift register shall shift right by one on each data-bit wrap; serial_data_out shall present bit 0.
REQ-017 One-entry holding buffer:
  - A request while tx_busy = 1 and the buffer is empty shall store data_in in the buffer.
  - A request while the buffer is full shall pulse overflow_error on the next cycle; data_in is dropped and the buffer is unchanged.
REQ-018 At the end of STOP with the buffer full:
  - The FSM shall go directly to START, with no idle gap.
  - The buffer content shall load into the shift register and the buffer shall empty.
REQ-019 A request in the same cycle that the last STOP cycle ends with an empty buffer shall be stored in the buffer and sent back-to-back.
REQ-020 tx_done shall be high during the last cycle of STOP.
REQ-021 break_req shall be honoured only in IDLE with the buffer empty and tx_start_n high. tx_start_n takes precedence when both are asserted.
REQ-022 BREAK shall:
  - drive serial_data_out = 0 for (DATA_SIZE+2)*OVERSAMPLE cycles;
  - then send STOP (1 for OVERSAMPLE cycles);
  - pulse tx_done at the end and return to IDLE.
REQ-023 Requests during BREAK shall use the holding buffer under the same rules as REQ-017.
REQ-024 tx_busy shall equal (state != IDLE), registered.
REQ-025 data_in changes while tx_busy = 1 shall not alter the frame in flight.

Reset
REQ-026 While reset_n = 0 (asynchronously, including mid-frame):
  - serial_data_out = 1; tx_busy, tx_done, overflow_error = 0.
  - state = IDLE; counters = 0; shift register = 0; holding buffer empty.
REQ-027 After reset_n rises, the first request shall be accepted no earlier than the first rising edge with reset_n = 1.

Verification
REQ-028 Send 0xA5 from IDLE -> line 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit 16 cycles; tx_done pulses at cycle 176; tx_busy falls at cycle 177.
REQ-029 Send 0x07 -> parity bit 1; loopback into the receiver yields data 0x07 with no parity, stop or break error.
REQ-030 Request 0x3C at cycle 0, 0xC3 at cycle 40, 0xFF at cycle 60 -> 0x3C and 0xC3 are sent back-to-back (line high only during stop bits); overflow_error pulses once at cycle 61; 0xFF is never sent.
REQ-031 break_req in IDLE -> line low for 160 cycles, high for 16 cycles, then tx_done; the receiver flags break_error.
REQ-032 Assert reset_n = 0 at cycle 50 of a frame -> line immediately 1 and tx_busy = 0; a new request after release sends a clean full frame.
REQ-033 Assert tx_start_n and break_req in the same IDLE cycle -> a data frame is sent and break_req is ignored.
